// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its AXI-lite read master.
package ifu_fetch_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_RESP_W = 2;

  localparam logic [31:0]           INST_NOP  = 32'h0000_0013;
  localparam logic [AXI_RESP_W-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_OUT,
    S_WAIT
  } ifu_state_t;

  function automatic logic resp_is_err(input logic [AXI_RESP_W-1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// AXI-lite read channel (AR + R) between a read master and a memory slave.
// A beat transfers on the rising clk edge where valid & ready are both 1; valid
// must not depend on ready, and payload is held stable while valid is high.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic [AXI_ADDR_W-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_DATA_W-1:0] rdata;
  logic [AXI_RESP_W-1:0] rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ifu_fetch_axi_lite_rd_master.sv
// Single-beat AXI-lite read master: issues one AR while start is high and
// captures the matching R beat; shared by the fetch and load paths.
module axi_lite_rd_master
  import ifu_fetch_pkg::*;
#(
  parameter logic [AXI_DATA_W-1:0] DATA_RST = INST_NOP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AXI_ADDR_W-1:0] addr,
  output logic                  done,
  output logic [AXI_DATA_W-1:0] data,
  output logic [AXI_RESP_W-1:0] resp,
  ifu_fetch_if.master           axi
);

  logic ar_done;
  logic ar_fire;
  logic r_fire;

  // start must come from registered state so no input reaches arvalid/rready.
  assign axi.arvalid = start & ~ar_done;
  assign axi.araddr  = addr;
  assign axi.rready  = start;

  assign ar_fire = axi.arvalid & axi.arready;
  // An R beat only counts once its AR has been (or is being) accepted.
  assign r_fire  = axi.rvalid & axi.rready & (ar_done | ar_fire);
  assign done    = r_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar_done <= 1'b0;
      data    <= DATA_RST;
      resp    <= RESP_OKAY;
    end else begin
      if (!start || r_fire) begin
        ar_done <= 1'b0;
      end else if (ar_fire) begin
        ar_done <= 1'b1;
      end
      if (r_fire) begin
        data <= axi.rdata;
        resp <= axi.rresp;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_r_before_ar: assert property (@(posedge clk) disable iff (!rst_n)
    !(start && axi.rvalid && !ar_done && !ar_fire))
    else $error("rvalid asserted before AR handshake");
`endif

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, reads one instruction per PC over
// AXI-lite, offers it to decode, then waits for writeback's next PC.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter logic [31:0] FETCH_ERR_INST = INST_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master axi,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        wb_valid,
  input  logic [31:0] wb_dnpc,
  output ifu_state_t  state_dbg
);

  ifu_state_t state;
  ifu_state_t next_state;
  logic [31:0] pc;

  logic                  rd_start;
  logic                  rd_done;
  logic [AXI_DATA_W-1:0] rd_data;
  logic [AXI_RESP_W-1:0] rd_resp;

  assign rd_start = (state == S_REQ);

  axi_lite_rd_master #(
    .DATA_RST (INST_NOP)
  ) u_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (rd_start),
    .addr  (pc),
    .done  (rd_done),
    .data  (rd_data),
    .resp  (rd_resp),
    .axi   (axi)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: next_state = S_REQ;
      S_REQ:  if (rd_done) next_state = S_OUT;
      S_OUT:  if (inst_ready) next_state = S_WAIT;
      S_WAIT: if (wb_valid) next_state = S_REQ;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      // The IFU never increments the PC itself; writeback supplies every next PC.
      if (state == S_WAIT && wb_valid) begin
        pc <= wb_dnpc;
      end
    end
  end

  assign inst_valid = (state == S_OUT);
  assign inst_err   = resp_is_err(rd_resp);
  assign inst       = resp_is_err(rd_resp) ? FETCH_ERR_INST : rd_data;
  assign inst_pc    = pc;
  assign state_dbg  = state;

`ifndef SYNTHESIS
  a_wb_ignored: assert property (@(posedge clk) disable iff (!rst_n)
    (wb_valid && state != S_WAIT) |=> (pc == $past(pc)))
    else $error("wb_valid outside S_WAIT altered pc");
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a transaction-level slave/decode/writeback
// driver and an expected-instruction queue built from the fetch rules.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_valid;
  logic        inst_ready;
  logic        wb_valid;
  logic [31:0] wb_dnpc;
  ifu_state_t  state_dbg;

  ifu_fetch_if axi_if ();

  ifu_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axi        (axi_if),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_err   (inst_err),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .wb_valid   (wb_valid),
    .wb_dnpc    (wb_dnpc),
    .state_dbg  (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {err, pc, inst}
  logic [64:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_arvalid"},   32'(axi_if.arvalid), 32'd0);
    check_eq({tag, "_rready"},    32'(axi_if.rready),  32'd0);
    check_eq({tag, "_inst_valid"}, 32'(inst_valid),    32'd0);
    check_eq({tag, "_inst_err"},  32'(inst_err),       32'd0);
    check_eq({tag, "_inst"},      inst,                INST_NOP);
    check_eq({tag, "_inst_pc"},   inst_pc,             RST_PC);
  endtask

  task automatic wait_arvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (axi_if.arvalid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check_eq("arvalid_timeout", 32'd0, 32'd1);
  endtask

  // driver: one complete fetch from request through writeback
  task automatic fetch_one(input logic [31:0] exp_pc, input logic [31:0] next_pc,
                           input logic [31:0] data_v, input logic [1:0] resp_v,
                           input int lat, input bit split, input int lat2,
                           input int bp, input int wbw);
    bit ok;
    logic [64:0] e;
    logic [31:0] exp_inst;
    wait_arvalid(ok);
    if (!ok) return;
    check_eq("araddr", axi_if.araddr, exp_pc);
    check_eq("rready", 32'(axi_if.rready), 32'd1);
    exp_inst = (resp_v == 2'b00) ? data_v : 32'h0000_0013;
    exp_q.push_back({(resp_v != 2'b00), exp_pc, exp_inst});

    for (int i = 0; i < lat; i++) begin
      wb_valid = 1'($urandom_range(0, 1));
      wb_dnpc  = $urandom;
      step();
      check_eq("arvalid_hold", 32'(axi_if.arvalid), 32'd1);
      check_eq("araddr_hold", axi_if.araddr, exp_pc);
    end
    wb_valid = 1'b0;

    axi_if.rdata = data_v;
    axi_if.rresp = resp_v;
    if (!split) begin
      axi_if.arready = 1'b1;
      axi_if.rvalid  = 1'b1;
      step();
      axi_if.arready = 1'b0;
      axi_if.rvalid  = 1'b0;
    end else begin
      axi_if.arready = 1'b1;
      step();
      axi_if.arready = 1'b0;
      check_eq("arvalid_drop", 32'(axi_if.arvalid), 32'd0);
      for (int i = 0; i < lat2; i++) begin
        step();
        check_eq("early_inst_valid", 32'(inst_valid), 32'd0);
      end
      axi_if.rvalid = 1'b1;
      step();
      axi_if.rvalid = 1'b0;
    end
    axi_if.rdata = $urandom;
    axi_if.rresp = 2'($urandom_range(0, 3));

    e = exp_q.pop_front();
    check_eq("inst_valid", 32'(inst_valid), 32'd1);
    check_eq("inst", inst, e[31:0]);
    check_eq("inst_pc", inst_pc, e[63:32]);
    check_eq("inst_err", 32'(inst_err), 32'(e[64]));

    inst_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      wb_valid = 1'($urandom_range(0, 1));
      wb_dnpc  = $urandom;
      step();
      check_eq("bp_inst_valid", 32'(inst_valid), 32'd1);
      check_eq("bp_inst", inst, e[31:0]);
      check_eq("bp_inst_pc", inst_pc, e[63:32]);
      check_eq("bp_arvalid", 32'(axi_if.arvalid), 32'd0);
    end
    wb_valid   = 1'b0;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check_eq("inst_valid_drop", 32'(inst_valid), 32'd0);

    for (int i = 0; i < wbw; i++) begin
      step();
      check_eq("wait_arvalid", 32'(axi_if.arvalid), 32'd0);
    end
    wb_valid = 1'b1;
    wb_dnpc  = next_pc;
    step();
    wb_valid = 1'b0;
    wb_dnpc  = $urandom;
  endtask

  initial begin
    bit ok;
    logic [31:0] pc_cur;
    logic [31:0] pc_nxt;
    logic [1:0]  resp_r;

    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rdata   = '0;
    axi_if.rresp   = 2'b00;
    inst_ready     = 1'b0;
    wb_valid       = 1'b0;
    wb_dnpc        = '0;

    rst_n = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    check_eq("quiet_after_rst", 32'(axi_if.arvalid), 32'd0);
    step();
    check_eq("arvalid_rise", 32'(axi_if.arvalid), 32'd1);

    // directed: zero-wait, isram-style, error response, recovery
    fetch_one(RST_PC, 32'h8000_0010, 32'h0010_0093, 2'b00, 0, 1'b0, 0, 0, 0);
    fetch_one(32'h8000_0010, 32'h8000_0014, mem_at(32'h8000_0010), 2'b00, 1, 1'b0, 0, 5, 1);
    fetch_one(32'h8000_0014, 32'h8000_0018, mem_at(32'h8000_0014), 2'b10, 0, 1'b1, 1, 0, 0);
    fetch_one(32'h8000_0018, 32'hFFFF_FFFC, mem_at(32'h8000_0018), 2'b00, 2, 1'b0, 0, 1, 2);
    fetch_one(32'hFFFF_FFFC, 32'h0000_0003, mem_at(32'hFFFF_FFFC), 2'b00, 0, 1'b1, 0, 0, 0);
    pc_cur = 32'h0000_0003;

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      pc_nxt = $urandom;
      resp_r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fetch_one(pc_cur, pc_nxt, mem_at(pc_cur), resp_r,
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 2)));
      pc_cur = pc_nxt;
    end

    // reset after AR accepted, R still outstanding
    wait_arvalid(ok);
    check_eq("mid_araddr", axi_if.araddr, pc_cur);
    axi_if.arready = 1'b1;
    step();
    axi_if.arready = 1'b0;
    rst_n = 1'b0;
    step();
    check_reset_outputs("mid_rst");
    rst_n = 1'b1;
    check_eq("mid_quiet", 32'(axi_if.arvalid), 32'd0);
    step();
    check_eq("mid_arvalid_rise", 32'(axi_if.arvalid), 32'd1);
    fetch_one(RST_PC, 32'h8000_0004, mem_at(RST_PC), 2'b00, 1, 1'b0, 0, 2, 0);
    fetch_one(32'h8000_0004, 32'h8000_0008, mem_at(32'h8000_0004), 2'b00, 0, 1'b0, 0, 0, 0);

    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
